if_fetch_stage: RTL and testbench

Instruction-fetch stage of the RV32I core, directly upstream of the decode/control stage. Holds the program counter, issues word requests to instruction memory over a valid/ready port, buffers returned instructions in a small in-order FIFO, and presents instruction, PC and 7-bit opcode to decode with a valid/ready handshake. Branch/jump redirects from execute flush the buffer and discard any in-flight responses.

---
 rtl/if_fetch_stage_if.sv | 32 +++
 rtl/if_fetch_stage.sv | 134 +++++++++++++
 tb/tb_if_fetch_stage.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect and
// the decode-side handshake. The fetch stage is the master; memory/decode the slave.
interface if_fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc, id_opcode,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc, id_opcode,
    output id_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC, credit-limited imem requests, in-order
// instruction FIFO and redirect flush. FETCH_ALIGN_CHECK_EN enables misaligned-redirect halt.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  if_fetch_stage_if.master      bus,
  output logic                  fetch_fault
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN, HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic          fault_q, fault_d;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic          accept, pop, push, rsp;
  logic          redir_bad;
  logic [31:0]   redir_tgt;
  logic [CW:0]   used, limit;
  logic [31:0]   head_instr;

  assign rsp    = bus.imem_rsp_valid;
  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign pop    = (occ_q != '0) && bus.id_ready;
  assign push   = rsp && (drop_q == '0) && (state_q == RUN) && !bus.redirect_valid;

  // Credit counts buffered entries plus every in-flight request, including ones
  // that will be dropped, so a returning response always has a FIFO slot.
  assign used  = {1'b0, occ_q} + {1'b0, outst_q};
  assign limit = (CW+1)'(DEPTH) + (CW+1)'(pop);

  assign bus.imem_req_valid = rst_n && (state_q == RUN) && !bus.redirect_valid && (used < limit);
  assign bus.imem_req_addr  = pc_q & 32'hFFFF_FFFC;

  assign head_instr    = (occ_q != '0) ? instr_mem[rd_q] : 32'h0;
  assign bus.id_valid  = (occ_q != '0);
  assign bus.id_instr  = head_instr;
  assign bus.id_pc     = (occ_q != '0) ? pc_mem[rd_q] : 32'h0;
  assign bus.id_opcode = head_instr[6:0];

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_bad   = (bus.redirect_pc[1:0] != 2'b00);
  assign redir_tgt   = bus.redirect_pc;
  assign fetch_fault = fault_q;
`else
  assign redir_bad   = 1'b0;
  assign redir_tgt   = bus.redirect_pc & 32'hFFFF_FFFC;
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    occ_d    = occ_q;
    drop_d   = drop_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    fault_d  = fault_q;
    outst_d  = outst_q + CW'(accept) - CW'(rsp);

    // A redirect discards everything already fetched; a response landing in the
    // same cycle is counted as dropped, the rest are dropped as they return.
    if (bus.redirect_valid) begin
      occ_d    = '0;
      rd_d     = '0;
      wr_d     = '0;
      drop_d   = outst_q - CW'(rsp);
      pc_d     = redir_tgt;
      rsp_pc_d = redir_tgt;
      if (redir_bad) begin
        state_d = HALT;
        fault_d = 1'b1;
      end
    end else begin
      if (accept)
        pc_d = pc_q + 32'd4;
      if (rsp && (drop_q != '0))
        drop_d = drop_q - CW'(1);
      if (push) begin
        wr_d     = wr_q + PW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop)
        rd_d = rd_q + PW'(1);
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      occ_q    <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      occ_q    <= occ_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      fault_q  <= fault_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_q] <= bus.imem_rsp_data;
      pc_mem[wr_q]    <= rsp_pc_q;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a memory model feeds responses, accepted
// fetches queue expected {pc, instr}, and a negedge monitor checks every output.
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          live;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic fetch_fault;

  if_fetch_stage_if bus();

  if_fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          acc_count = 0;
  int          pop_count = 0;
  int          first_acc = -1;
  int          first_val = -1;
  int          last_due = 0;
  int          lat = 1;
  bit          rand_lat = 1'b0;
  bit          halted = 1'b0;
  bit          exp_fault = 1'b0;
  int          arrived = 0;
  logic [31:0] req_pc = RESET_PC;
  mem_t        memq[$];
  exp_t        sb[$];

  int          a0, p0;
  logic        r_redir, r_idr, r_mrdy;
  logic [31:0] r_tgt;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model update, run late in each cycle after the monitor has sampled.
  task automatic updateModel();
    mem_t e;
    int   due;
    if (bus.imem_rsp_valid && memq.size() > 0) begin
      e = memq.pop_front();
      if (e.live) arrived++;
    end
    if (bus.redirect_valid) begin
      sb.delete();
      arrived = 0;
      for (int i = 0; i < memq.size(); i++) memq[i].live = 1'b0;
      req_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      if (ALIGN_CHK && bus.redirect_pc[1:0] != 2'b00) begin
        halted    = 1'b1;
        exp_fault = 1'b1;
      end
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      if (rand_lat) lat = $urandom_range(1, 3);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{due, memfn(bus.imem_req_addr), 1'b1});
      sb.push_back('{req_pc, memfn(req_pc)});
      req_pc = req_pc + 32'd4;
    end
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] tgt,
                               input logic idr, input logic mrdy);
    @(posedge clk);
    #1;
    cyc++;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.id_ready       = idr;
    bus.imem_req_ready = mrdy;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memq[0].data;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
    @(negedge clk);
    #2;
    updateModel();
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    memq.delete();
    sb.delete();
    arrived   = 0;
    req_pc    = RESET_PC;
    halted    = 1'b0;
    exp_fault = 1'b0;
    last_due  = 0;
    first_acc = -1;
    first_val = -1;
    rst_n     = 1'b1;
  endtask

  // Monitor: compares DUT outputs with the scoreboard and retires popped entries.
  always @(negedge clk) begin
    int lvl;
    bit mpop;
    bit exp_req;
    if (!rst_n) begin
      checkOutput("rst_req_valid", bus.imem_req_valid, 0);
      checkOutput("rst_id_valid",  bus.id_valid, 0);
      checkOutput("rst_fault",     fetch_fault, 0);
      checkOutput("rst_id_instr",  bus.id_instr, 0);
      checkOutput("rst_id_pc",     bus.id_pc, 0);
      checkOutput("rst_id_opcode", bus.id_opcode, 0);
    end else begin
      lvl = sb.size();
      for (int i = 0; i < memq.size(); i++) if (!memq[i].live) lvl++;
      mpop    = (arrived > 0) && bus.id_ready && !bus.redirect_valid;
      exp_req = !halted && !bus.redirect_valid && ((lvl - int'(mpop)) < DEPTH);
      checkOutput("req_valid", bus.imem_req_valid, exp_req);
      checkOutput("id_valid",  bus.id_valid, (arrived > 0));
      checkOutput("fault",     fetch_fault, exp_fault);
      if (arrived > 0 && sb.size() > 0) begin
        checkOutput("id_pc",     bus.id_pc, sb[0].pc);
        checkOutput("id_instr",  bus.id_instr, sb[0].instr);
        checkOutput("id_opcode", bus.id_opcode, {25'h0, sb[0].instr[6:0]});
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        checkOutput("req_addr", bus.imem_req_addr, req_pc);
        acc_count++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (bus.id_valid && first_val < 0) first_val = cyc;
      if (bus.id_valid && bus.id_ready && !bus.redirect_valid) pop_count++;
      if (mpop && sb.size() > 0) begin
        void'(sb.pop_front());
        arrived--;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;

    // Streaming with single-cycle memory: latency and one instruction per cycle.
    doReset();
    lat = 1;
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("first_latency", first_val - first_acc, 2);
    p0 = pop_count;
    repeat (20) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("throughput", pop_count - p0, 20);

    // Decode stalled: credit caps requests, then nothing is lost on release.
    doReset();
    a0 = acc_count;
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stall_requests", acc_count - a0, DEPTH);
    p0 = pop_count;
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("release_pops", pop_count - p0, 10);

    // Redirect with two responses in flight on a three-cycle memory.
    doReset();
    lat = 3;
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    p0 = pop_count;
    repeat (20) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("redirect_progress", (pop_count - p0) > 0, 1);

    // Redirect coinciding with a pop and a response arrival, then PC wrap.
    doReset();
    lat = 1;
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    // Randomised traffic, including a reset while requests are in flight.
    rand_lat = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      r_redir = ($urandom_range(0, 99) < 5);
      r_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C))
                                            : ($urandom & 32'hFFFF_FFFC);
      r_idr   = ($urandom_range(0, 99) < 70);
      r_mrdy  = ($urandom_range(0, 99) < 75);
      applyStimulus(r_redir, r_tgt, r_idr, r_mrdy);
    end
    doReset();
    for (int i = 0; i < 60; i++) begin
      r_idr  = ($urandom_range(0, 99) < 70);
      r_mrdy = ($urandom_range(0, 99) < 75);
      applyStimulus(1'b0, 32'h0, r_idr, r_mrdy);
    end
    rand_lat = 1'b0;

    // Misaligned redirect: halts with the check enabled, realigns otherwise.
    doReset();
    lat = 1;
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0000_0102, 1'b1, 1'b1);
    p0 = pop_count;
    a0 = acc_count;
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("misalign_progress", (pop_count - p0) > 0, ALIGN_CHK ? 0 : 1);
    checkOutput("misalign_requests", (acc_count - a0) > 0, ALIGN_CHK ? 0 : 1);
    doReset();
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
